// File: rtl/i2s_frame_mixer_sched.sv
// Per-frame voice scheduler/mixer feeding i2s_tx_mod: round-robin collection of
// one stereo sample per voice, saturating sum, one published pair per frame.
module i2s_frame_mixer_sched #(
  parameter int BITWIDTH       = 24,
  parameter int NUM_VOICES     = 4,
  parameter int COLLECT_CYCLES = 64
) (
  input  logic                           ctl_clk,
  input  logic                           ctl_rst,
  input  logic                           frame_req,
  input  logic [NUM_VOICES-1:0]          voice_req,
  input  logic [NUM_VOICES*BITWIDTH-1:0] voice_l,
  input  logic [NUM_VOICES*BITWIDTH-1:0] voice_r,
  output logic [NUM_VOICES-1:0]          voice_ack,
  output logic [BITWIDTH-1:0]            wave_out_l,
  output logic [BITWIDTH-1:0]            wave_out_r,
  output logic                           frame_valid,
  output logic [NUM_VOICES-1:0]          missed_mask,
  output logic                           overrun,
  input  logic                           overrun_clr
);

  localparam int PW = $clog2(NUM_VOICES);
  localparam int AW = BITWIDTH + PW;
  localparam int CW = $clog2(COLLECT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PUBLISH} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [NUM_VOICES-1:0] served_q, served_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BITWIDTH-1:0]   wave_l_q, wave_l_d, wave_r_q, wave_r_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [NUM_VOICES-1:0] missed_q, missed_d;
  logic                  overrun_q, overrun_d;

  logic                  grant_any;
  logic [PW-1:0]         grant_idx;
  logic [BITWIDTH-1:0]   grant_l, grant_r;
  logic [NUM_VOICES-1:0] served_next;

  // In range exactly when the bits above the target sign bit all equal it.
  function automatic logic [BITWIDTH-1:0] saturate(input logic [AW-1:0] a);
    logic [PW:0] top;
    top = a[AW-1:BITWIDTH-1];
    if (top == '0 || top == '1) return a[BITWIDTH-1:0];
    else if (a[AW-1])           return {1'b1, {(BITWIDTH-1){1'b0}}};
    else                        return {1'b0, {(BITWIDTH-1){1'b1}}};
  endfunction

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    voice_ack = '0;
    if (state_q == S_COLLECT) begin
      for (int unsigned off = 0; off < NUM_VOICES; off++) begin
        idx = 32'(rr_ptr_q) + off;
        if (idx >= NUM_VOICES) idx = idx - NUM_VOICES;
        if (!grant_any && voice_req[idx] && !served_q[idx]) begin
          grant_any = 1'b1;
          grant_idx = PW'(idx);
        end
      end
      if (grant_any) voice_ack[grant_idx] = 1'b1;
    end
  end

  assign grant_l     = voice_l[int'(grant_idx)*BITWIDTH +: BITWIDTH];
  assign grant_r     = voice_r[int'(grant_idx)*BITWIDTH +: BITWIDTH];
  assign served_next = served_q | voice_ack;

  always_comb begin
    state_d       = state_q;
    acc_l_d       = acc_l_q;
    acc_r_d       = acc_r_q;
    served_d      = served_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    wave_l_d      = wave_l_q;
    wave_r_d      = wave_r_q;
    frame_valid_d = 1'b0;
    missed_d      = missed_q;
    overrun_d     = overrun_q;

    unique case (state_q)
      S_IDLE: begin
        if (frame_req) begin
          acc_l_d  = '0;
          acc_r_d  = '0;
          served_d = '0;
          cnt_d    = CW'(COLLECT_CYCLES);
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        served_d = served_next;
        cnt_d    = cnt_q - CW'(1);
        if (grant_any) begin
          acc_l_d  = acc_l_q + {{PW{grant_l[BITWIDTH-1]}}, grant_l};
          acc_r_d  = acc_r_q + {{PW{grant_r[BITWIDTH-1]}}, grant_r};
          rr_ptr_d = (grant_idx == PW'(NUM_VOICES-1)) ? '0 : grant_idx + PW'(1);
        end
        // The cycle that decrements the counter to zero is the last COLLECT cycle.
        if (&served_next || cnt_q == CW'(1)) state_d = S_PUBLISH;
      end
      S_PUBLISH: begin
        wave_l_d      = saturate(acc_l_q);
        wave_r_d      = saturate(acc_r_q);
        missed_d      = ~served_q;
        frame_valid_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_req && state_q != S_IDLE) overrun_d = 1'b1;
    else if (overrun_clr)               overrun_d = 1'b0;
  end

  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      state_q       <= S_IDLE;
      acc_l_q       <= '0;
      acc_r_q       <= '0;
      served_q      <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      wave_l_q      <= '0;
      wave_r_q      <= '0;
      frame_valid_q <= 1'b0;
      missed_q      <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_l_q       <= acc_l_d;
      acc_r_q       <= acc_r_d;
      served_q      <= served_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      wave_l_q      <= wave_l_d;
      wave_r_q      <= wave_r_d;
      frame_valid_q <= frame_valid_d;
      missed_q      <= missed_d;
      overrun_q     <= overrun_d;
    end
  end

  assign wave_out_l  = wave_l_q;
  assign wave_out_r  = wave_r_q;
  assign frame_valid = frame_valid_q;
  assign missed_mask = missed_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_frame_mixer_sched.sv
// Scoreboard bench for i2s_frame_mixer_sched: expected mixes are queued at each
// frame request and compared when frame_valid pulses; ack order/timing logged per frame.
module tb_i2s_frame_mixer_sched;

  localparam int BW = 24;
  localparam int NV = 4;
  localparam int CC = 64;

  logic            ctl_clk = 1'b0;
  logic            ctl_rst = 1'b0;
  logic            frame_req = 1'b0;
  logic            overrun_clr = 1'b0;
  logic [NV-1:0]   voice_req = '0;
  logic [NV-1:0]   voice_ack, missed_mask;
  logic [NV*BW-1:0] voice_l, voice_r;
  logic [BW-1:0]   wave_out_l, wave_out_r;
  logic            frame_valid, overrun;
  logic [BW-1:0]   vl[NV];
  logic [BW-1:0]   vr[NV];

  typedef struct {
    logic [BW-1:0] l;
    logic [BW-1:0] r;
    logic [NV-1:0] m;
  } exp_t;

  exp_t          sb[$];
  int            ack_log[$];
  int            n_total = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            t0 = 0;
  int            fv_rel = -1;
  logic [NV-1:0] drop_pending = '0;

  always #5 ctl_clk = ~ctl_clk;

  assign voice_l = {vl[3], vl[2], vl[1], vl[0]};
  assign voice_r = {vr[3], vr[2], vr[1], vr[0]};

  i2s_frame_mixer_sched #(
    .BITWIDTH      (BW),
    .NUM_VOICES    (NV),
    .COLLECT_CYCLES(CC)
  ) dut (
    .ctl_clk    (ctl_clk),
    .ctl_rst    (ctl_rst),
    .frame_req  (frame_req),
    .voice_req  (voice_req),
    .voice_l    (voice_l),
    .voice_r    (voice_r),
    .voice_ack  (voice_ack),
    .wave_out_l (wave_out_l),
    .wave_out_r (wave_out_r),
    .frame_valid(frame_valid),
    .missed_mask(missed_mask),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] sat24(input int s);
    logic [31:0] u;
    if (s > 8388607)  return 24'h7FFFFF;
    if (s < -8388608) return 24'h800000;
    u = s;
    return u[BW-1:0];
  endfunction

  // Reference mix over the voices expected to be served this frame.
  task automatic push_exp(input logic [NV-1:0] mask);
    exp_t e;
    int sl, sr;
    sl = 0;
    sr = 0;
    for (int i = 0; i < NV; i++) begin
      if (mask[i]) begin
        sl += int'($signed(vl[i]));
        sr += int'($signed(vr[i]));
      end
    end
    e.l = sat24(sl);
    e.r = sat24(sr);
    e.m = ~mask;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge ctl_clk);
    #1;
    voice_req    = voice_req & ~drop_pending;
    drop_pending = '0;
    frame_req    = 1'b0;
    overrun_clr  = 1'b0;
    cyc++;
    @(negedge ctl_clk);
    check("ack_legal", {62'd0, $onehot0(voice_ack), |(voice_ack & ~voice_req)}, 64'd2);
    for (int i = 0; i < NV; i++) begin
      if (voice_ack[i]) begin
        ack_log.push_back(i * 1000 + (cyc - t0));
        drop_pending[i] = 1'b1;
      end
    end
    if (frame_valid) begin
      fv_rel = cyc - t0;
      if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check("mix_l", wave_out_l, e.l);
        check("mix_r", wave_out_r, e.r);
        check("missed", missed_mask, e.m);
      end
    end
  endtask

  task automatic start_frame(input logic [NV-1:0] mask);
    push_exp(mask);
    ack_log.delete();
    fv_rel    = -1;
    t0        = cyc;
    frame_req = 1'b1;
    step();
  endtask

  task automatic wait_frame(input int exp_rel);
    int n;
    n = 0;
    while (fv_rel < 0 && n < 200) begin
      step();
      n++;
    end
    if (fv_rel < 0) check("frame_timeout", 64'd0, 64'd1);
    else            check("frame_latency", 64'(fv_rel), 64'(exp_rel));
  endtask

  task automatic check_acks(input int n, input logic [15:0] order, input int first);
    logic [3:0] v;
    check("ack_count", 64'(ack_log.size()), 64'(n));
    for (int k = 0; k < n && k < ack_log.size(); k++) begin
      v = order[4*k +: 4];
      check("ack_order", 64'(ack_log[k]), 64'(int'(v) * 1000 + first + k));
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < NV; i++) begin
      vl[i] = 24'(i + 1);
      vr[i] = 24'hFFFFFF;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got 0x0 want 0x1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with random stimulus
    for (int i = 0; i < NV; i++) begin
      vl[i] = '0;
      vr[i] = '0;
    end
    repeat (6) begin
      @(negedge ctl_clk);
      voice_req   = NV'($urandom);
      frame_req   = 1'($urandom);
      overrun_clr = 1'($urandom);
      for (int i = 0; i < NV; i++) begin
        vl[i] = BW'($urandom);
        vr[i] = BW'($urandom);
      end
      #1;
      check("rst_ack", voice_ack, 0);
      check("rst_wave_l", wave_out_l, 0);
      check("rst_fv", frame_valid, 0);
    end
    @(negedge ctl_clk);
    frame_req   = 1'b0;
    overrun_clr = 1'b0;
    voice_req   = '1;
    ctl_rst     = 1'b1;
    repeat (5) begin
      step();
      check("idle_ack", voice_ack, 0);
    end
    check("rst_wave_r", wave_out_r, 0);
    check("rst_missed", missed_mask, 0);
    check("rst_overrun", overrun, 0);
    drop_pending = '0;

    // Basic mix
    load_basic();
    voice_req = '1;
    start_frame(4'b1111);
    wait_frame(6);
    check_acks(4, 16'h3210, 1);
    check("basic_l_abs", wave_out_l, 24'h00000A);
    check("basic_r_abs", wave_out_r, 24'hFFFFFC);

    // Saturation, requested back-to-back in the cycle frame_valid is seen
    for (int i = 0; i < NV; i++) begin
      vl[i] = 24'h400000;
      vr[i] = 24'hC00000;
    end
    voice_req = '1;
    start_frame(4'b1111);
    wait_frame(6);
    check_acks(4, 16'h3210, 1);
    check("sat_l_abs", wave_out_l, 24'h7FFFFF);
    check("sat_r_abs", wave_out_r, 24'h800000);
    step();
    check("fv_pulse", frame_valid, 0);
    check("wave_hold", wave_out_l, 24'h7FFFFF);

    // Timeout: voices 1 and 3 only; idle voices carry data that must not leak in
    vl[0] = 24'h7FFFFF; vr[0] = 24'h7FFFFF;
    vl[1] = 24'h123456; vr[1] = 24'hFFF000;
    vl[2] = 24'h7FFFFF; vr[2] = 24'h7FFFFF;
    vl[3] = 24'h0F0F0F; vr[3] = 24'h800001;
    voice_req = 4'b1010;
    start_frame(4'b1010);
    wait_frame(CC + 2);
    check_acks(2, 16'h0031, 1);
    check("timeout_missed_abs", missed_mask, 4'b0101);

    // Round-robin carry-over across frames
    vl[2] = 24'h000100; vr[2] = 24'hFFFF00;
    voice_req = 4'b0100;
    start_frame(4'b0100);
    wait_frame(CC + 2);
    check_acks(1, 16'h0002, 1);
    load_basic();
    voice_req = '1;
    start_frame(4'b1111);
    wait_frame(6);
    check_acks(4, 16'h2103, 1);

    // Overrun during COLLECT; set beats a simultaneous clear
    step();
    voice_req = '1;
    start_frame(4'b1111);
    frame_req = 1'b1;
    step();
    check("overrun_set", overrun, 1);
    frame_req   = 1'b1;
    overrun_clr = 1'b1;
    step();
    check("overrun_set_wins", overrun, 1);
    wait_frame(6);
    check_acks(4, 16'h2103, 1);
    check("ovr_l_abs", wave_out_l, 24'h00000A);
    check("ovr_r_abs", wave_out_r, 24'hFFFFFC);
    overrun_clr = 1'b1;
    step();
    check("overrun_clr", overrun, 0);

    // Reset abort mid-COLLECT
    voice_req = '1;
    start_frame(4'b1111);
    check("abort_ack_pre", voice_ack, 4'b1000);
    ctl_rst = 1'b0;
    #1;
    check("abort_ack", voice_ack, 0);
    check("abort_wave_l", wave_out_l, 0);
    check("abort_wave_r", wave_out_r, 0);
    check("abort_fv", frame_valid, 0);
    void'(sb.pop_front());
    drop_pending = '0;
    step();
    check("abort_hold_ack", voice_ack, 0);
    ctl_rst   = 1'b1;
    voice_req = '1;
    step();
    start_frame(4'b1111);
    wait_frame(6);
    check_acks(4, 16'h3210, 1);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_frame_mixer_sched.md
# i2s_frame_mixer_sched

Per-frame sample scheduler that sits in front of `i2s_tx_mod` and produces its `wave_in_l`/`wave_in_r` words. On each frame request it polls up to `NUM_VOICES` voice generators in round-robin order and accepts one stereo sample from each. It sums the samples with saturation and publishes the mixed pair once per audio frame. Voices that miss the collection window are reported, and frame requests that arrive too early are flagged as overruns.

## Interface
- `BITWIDTH`, 24, signed two's-complement sample width; matches `i2s_tx_mod`.
- `NUM_VOICES`, 4, number of requesters, 2..16.
- `COLLECT_CYCLES`, 64, maximum length of the collection window in clocks, ≥ `NUM_VOICES`.

Ports:
- `ctl_clk` in 1: single clock for the whole block.
- `ctl_rst` in 1: asynchronous, active-low reset.
- `frame_req` in 1: 1-cycle pulse requesting the next frame; already synchronous to `ctl_clk` (derived from the LRCK frame edge).
- `voice_req` in `NUM_VOICES`: voice i has a sample pending; held high until acked.
- `voice_l` in `NUM_VOICES*BITWIDTH`: left sample of voice i, at bits [i*BITWIDTH +: BITWIDTH].
- `voice_r` in `NUM_VOICES*BITWIDTH`: right sample, same packing.
- `voice_ack` out `NUM_VOICES`: one-hot grant; sample taken at the clock edge ending the ack cycle.
- `wave_out_l` out `BITWIDTH`: mixed left sample, drives `wave_in_l`.
- `wave_out_r` out `BITWIDTH`: mixed right sample, drives `wave_in_r`.
- `frame_valid` out 1: 1-cycle pulse when `wave_out_*` is updated.
- `missed_mask` out `NUM_VOICES`: voices not served in the last published frame.
- `overrun` out 1: sticky flag; a `frame_req` arrived while not IDLE.
- `overrun_clr` in 1: clears `overrun`.

## Operation
- FSM states IDLE, COLLECT and PUBLISH; reset state is IDLE.
- **IDLE**
  - On `frame_req`: clear both accumulators and the served mask, load the window counter with `COLLECT_CYCLES`, go to COLLECT.
- **COLLECT**
  - Each cycle, grant the first voice at or after `rr_ptr` (wrapping) with `voice_req`=1 and served=0.
  - `voice_ack` is combinational from the state, served mask, `rr_ptr` and `voice_req`. At most one bit is high, and never outside COLLECT.
  - On a grant to voice i:
    - sign-extend `voice_l[i]` and `voice_r[i]` to `BITWIDTH+clog2(NUM_VOICES)` bits and add them to the accumulators;
    - set served[i];
    - set `rr_ptr` to (i+1) mod `NUM_VOICES`.
  - `rr_ptr` persists across frames and resets to 0.
  - The window counter decrements every COLLECT cycle.
  - Go to PUBLISH when the served mask is all ones (counting the grant made this cycle) or when the counter reaches 0 (the last cycle may still grant).
- **PUBLISH** (one cycle)
  - Saturate each accumulator to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
  - Register the results into `wave_out_l`/`wave_out_r`, set `missed_mask` = ~served, pulse `frame_valid`.
  - Return to IDLE.
- **Overruns**
  - `frame_req` in COLLECT or PUBLISH sets `overrun` and is otherwise ignored; the current frame is unaffected.
  - `overrun_clr` clears the flag. If `frame_req` is ignored in the same cycle, the set wins.
- **Missed voices**
  - An unserved voice contributes 0.
  - Its still-pending request is served in the next frame.

## Timing
- Reset values: `wave_out_l`=0, `wave_out_r`=0, `frame_valid`=0, `missed_mask`=0, `overrun`=0, `voice_ack`=0, `rr_ptr`=0, state IDLE.
- Reset asserted mid-frame returns the block to IDLE immediately:
  - `voice_ack` drops combinationally;
  - the partial sum is discarded and `wave_out_*` clears to 0.
- Latency, with `frame_req` sampled at edge E0:
  - COLLECT occupies cycles 1..k, where k = `NUM_VOICES` if every voice is requesting, else `COLLECT_CYCLES`.
  - PUBLISH is cycle k+1.
  - `frame_valid` and the new `wave_out_*` are visible in cycle k+2 (E0 + k+2 edges).
- `wave_out_*` holds its value between frames.
- A new `frame_req` is accepted in cycle k+2 (block back in IDLE).
- The voice handshake is one ack per frame per voice. A voice may drop `voice_req` the cycle after its ack. A request still held after the voice is served is not re-granted until the next frame.

## Test plan
All scenarios use `NUM_VOICES`=4 and `BITWIDTH`=24.

1. **Reset:** hold `ctl_rst`=0 with random inputs, then release → all outputs 0, no `voice_ack` until `frame_req`.
2. **Basic mix:** all voices requesting, L = 0x000001/2/3/4, R = 0xFFFFFF each, `frame_req` at E0 → acks in order 0,1,2,3 on cycles 1-4; `frame_valid` in cycle 6 with `wave_out_l`=0x00000A, `wave_out_r`=0xFFFFFC, `missed_mask`=0.
3. **Saturation:** every L = 0x400000 and every R = 0xC00000 → `wave_out_l`=0x7FFFFF, `wave_out_r`=0x800000.
4. **Timeout:** only voices 1 and 3 requesting, `COLLECT_CYCLES`=64 → acks 1 then 3; `frame_valid` at cycle 66 with `missed_mask`=4'b0101 and `wave_out` = the sum of voices 1 and 3.
5. **Round-robin:** one frame where only voice 2 requests, then a frame with all voices requesting → ack order 3,0,1,2.
6. **Overrun and reset abort:**
   - `frame_req` during COLLECT → `overrun`=1 and the frame result equals the scenario-2 result; `overrun_clr` → 0.
   - Assert `ctl_rst` mid-COLLECT → `voice_ack`=0 at once, `wave_out_*`=0.
